// File: rtl/jp_scan_pkg.sv
// Shared constants for the joypad scanner: register addresses, scan FSM
// encodings and button bit positions (also used by the debug HCI).
package jp_scan_pkg;

    localparam logic [15:0] JP1_ADDR = 16'h4016;
    localparam logic [15:0] JP2_ADDR = 16'h4017;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_BIT_LO = 3'd2;
    localparam logic [2:0] ST_BIT_HI = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [7:0] jp_btn_t;

    // Serial read shift: buttons move toward bit 0, released level fills bit 7.
    function automatic jp_btn_t shift_in_one(input jp_btn_t sh);
        return {1'b1, sh[7:1]};
    endfunction

endpackage

// File: rtl/jp_scan_if.sv
// CPU-side register bus for the joypad front-end ($4016/$4017).
interface jp_scan_if;
    logic [15:0] a_in;
    logic [7:0]  d_in;
    logic        wr_en_in;
    logic        rd_en_in;
    logic [7:0]  d_out;

    modport master (output a_in, output d_in, output wr_en_in, output rd_en_in, input d_out);
    modport slave  (input a_in, input d_in, input wr_en_in, input rd_en_in, output d_out);
endinterface

// File: rtl/jp_scan_fsm.sv
// Background pad poller: tick generator, latch/clock scan FSM and the
// committed button snapshot (1 = pressed) for both pads.
module jp_scan_fsm
    import jp_scan_pkg::*;
#(
    parameter int CLK_DIV    = 100,
    parameter int POLL_TICKS = 16000
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    jp_data1_i,
    input  logic    jp_data2_i,
    output logic    jp_clk_o,
    output logic    jp_latch_o,
    output jp_btn_t btn1_o,
    output jp_btn_t btn2_o
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (POLL_TICKS > 2) ? $clog2(POLL_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
    localparam logic [IW-1:0] POLL_LAST  = IW'(POLL_TICKS - 1);
    localparam logic [IW-1:0] LATCH_LAST = IW'(1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_s;
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    jp_btn_t       scan1_q, scan1_d, scan2_q, scan2_d;
    jp_btn_t       btn1_q, btn1_d, btn2_q, btn2_d;
    logic          clk_q, clk_d, latch_q, latch_d;

    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Free-running tick divider.
    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Scan FSM next state; data is sampled as each BIT_LO is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        scan1_d = scan1_q;
        scan2_d = scan2_q;
        btn1_d  = btn1_q;
        btn2_d  = btn2_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && (cnt_q == POLL_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_LATCH;
                end else if (tick_s) begin
                    cnt_d = cnt_q + IW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_LATCH: begin
                if (tick_s && (cnt_q == LATCH_LAST)) begin
                    cnt_d      = '0;
                    bit_d      = 4'd0;
                    scan1_d[0] = ~jp_data1_i;
                    scan2_d[0] = ~jp_data2_i;
                    state_d    = ST_BIT_LO;
                end else if (tick_s) begin
                    cnt_d = cnt_q + IW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_BIT_LO: begin
                if (tick_s) begin
                    state_d = ST_BIT_HI;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BIT_HI: begin
                if (tick_s && (bit_q == 4'd7)) begin
                    bit_d   = bit_q + 4'd1;
                    state_d = ST_COMMIT;
                end else if (tick_s) begin
                    bit_d            = bit_q + 4'd1;
                    scan1_d[bit_d[2:0]] = ~jp_data1_i;
                    scan2_d[bit_d[2:0]] = ~jp_data2_i;
                    state_d          = ST_BIT_LO;
                end else begin
                    state_d = state_q;
                end
            end
            ST_COMMIT: begin
                btn1_d  = scan1_q;
                btn2_d  = scan2_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pad pins are registered from the next state so they align with it.
    always_comb begin
        latch_d = (state_d == ST_LATCH);
        clk_d   = (state_d != ST_BIT_LO);
    end

    // State, counters, scan/commit registers and pad pins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd0;
            scan1_q    <= 8'h00;
            scan2_q    <= 8'h00;
            btn1_q     <= 8'h00;
            btn2_q     <= 8'h00;
            clk_q      <= 1'b1;
            latch_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            scan1_q    <= scan1_d;
            scan2_q    <= scan2_d;
            btn1_q     <= btn1_d;
            btn2_q     <= btn2_d;
            clk_q      <= clk_d;
            latch_q    <= latch_d;
        end
    end

    assign jp_clk_o   = clk_q;
    assign jp_latch_o = latch_q;
    assign btn1_o     = btn1_q;
    assign btn2_o     = btn2_q;

endmodule

// File: rtl/jp_scan.sv
// NES $4016/$4017 register front-end: strobe latch, per-pad serial shift
// registers fed from the background scanner, and the wired-OR read mux.
module jp_scan
    import jp_scan_pkg::*;
#(
    parameter int CLK_DIV    = 100,
    parameter int POLL_TICKS = 16000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    jp_scan_if.slave    bus,
    input  logic        jp_data1_in,
    input  logic        jp_data2_in,
    output logic        jp_clk,
    output logic        jp_latch
);

    jp_btn_t btn1_s, btn2_s;
    jp_btn_t sh1_q, sh1_d, sh2_q, sh2_d;
    logic    strobe_q, strobe_d;
    logic    wr_jp1_s, rd_jp1_s, rd_jp2_s;
    logic    unused_d_s;

    jp_scan_fsm #(
        .CLK_DIV    (CLK_DIV),
        .POLL_TICKS (POLL_TICKS)
    ) u_fsm (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .jp_data1_i (jp_data1_in),
        .jp_data2_i (jp_data2_in),
        .jp_clk_o   (jp_clk),
        .jp_latch_o (jp_latch),
        .btn1_o     (btn1_s),
        .btn2_o     (btn2_s)
    );

    assign unused_d_s = ^bus.d_in[7:1];
    assign wr_jp1_s   = bus.wr_en_in && (bus.a_in == JP1_ADDR);
    assign rd_jp1_s   = bus.rd_en_in && (bus.a_in == JP1_ADDR);
    assign rd_jp2_s   = bus.rd_en_in && (bus.a_in == JP2_ADDR);

    // Strobe bit and snapshot shifting; strobe high keeps reloading from btn.
    always_comb begin
        strobe_d = strobe_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        if (wr_jp1_s) begin
            strobe_d = bus.d_in[0];
        end else begin
            strobe_d = strobe_q;
        end
        if (strobe_q) begin
            sh1_d = btn1_s;
            sh2_d = btn2_s;
        end else if (rd_jp1_s) begin
            sh1_d = shift_in_one(sh1_q);
        end else if (rd_jp2_s) begin
            sh2_d = shift_in_one(sh2_q);
        end else begin
            sh1_d = sh1_q;
            sh2_d = sh2_q;
        end
    end

    // Strobe and shift register state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            strobe_q <= 1'b0;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
        end else begin
            strobe_q <= strobe_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
        end
    end

    // Read mux drives zero off-address so it can be ORed onto the CPU bus.
    always_comb begin
        bus.d_out = 8'h00;
        case (bus.a_in)
            JP1_ADDR: bus.d_out = {7'b0000000, sh1_q[BTN_A]};
            JP2_ADDR: bus.d_out = {7'b0000000, sh2_q[BTN_A]};
            default:  bus.d_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_jp_scan.sv
// Directed plus randomized bench for jp_scan with a behavioural 4021-style pad
// model and a read model based on the committed snapshot and read count.
module tb_jp_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jd1, jd2, jclk, jlat;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] pad1_lv = 8'hFF;
    logic [7:0] pad2_lv = 8'hFF;
    logic [7:0] pad1_sr = 8'hFF;
    logic [7:0] pad2_sr = 8'hFF;
    logic       jclk_prev = 1'b1;

    jp_scan_if bus_if ();

    jp_scan #(.CLK_DIV(4), .POLL_TICKS(10)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .bus         (bus_if),
        .jp_data1_in (jd1),
        .jp_data2_in (jd2),
        .jp_clk      (jclk),
        .jp_latch    (jlat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: parallel load while latch high, shift on jp_clk rising edge.
    always @(posedge clk) begin
        jclk_prev <= jclk;
        if (jlat) begin
            pad1_sr <= pad1_lv;
            pad2_sr <= pad2_lv;
        end else if (jclk && !jclk_prev) begin
            pad1_sr <= {1'b1, pad1_sr[7:1]};
            pad2_sr <= {1'b1, pad2_sr[7:1]};
        end
    end
    assign jd1 = pad1_sr[0];
    assign jd2 = pad2_sr[0];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected k-th serial read of a snapshot: button bits, then released 1s.
    function automatic logic exp_rd(input logic [7:0] snap, input int k);
        return (k < 8) ? snap[k] : 1'b1;
    endfunction

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus_if.a_in = addr; bus_if.d_in = data; bus_if.wr_en_in = 1'b1;
        @(negedge clk);
        bus_if.wr_en_in = 1'b0; bus_if.a_in = 16'h0000; bus_if.d_in = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] v);
        @(negedge clk);
        bus_if.a_in = addr; bus_if.rd_en_in = 1'b1;
        #1 v = bus_if.d_out;
        @(negedge clk);
        bus_if.rd_en_in = 1'b0; bus_if.a_in = 16'h0000;
    endtask

    task automatic strobe_pulse();
        bus_write(16'h4016, 8'h01);
        bus_write(16'h4016, 8'h00);
    endtask

    task automatic wait_scan();
        int n;
        n = 0;
        @(negedge clk);
        while (jlat !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        chk("latch_seen", {31'd0, jlat}, 32'd1);
        n = 0;
        while (jlat === 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (70) @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] snap1, snap2;
        int n, w, t0, extra, r1, r2, sel;

        bus_if.a_in = 16'h4016; bus_if.d_in = 8'h00;
        bus_if.wr_en_in = 1'b0; bus_if.rd_en_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", bus_if.d_out, 32'h00);
        chk("rst_jclk", jclk, 32'd1);
        chk("rst_jlat", jlat, 32'd0);
        rst = 1'b0;
        bus_if.a_in = 16'h0000;

        // Waveform timing with CLK_DIV=4, POLL_TICKS=10.
        n = 0;
        while (jlat !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        t0 = cyc;
        w = 0;
        while (jlat === 1'b1 && w < 100) begin @(negedge clk); w++; end
        chk("latch_width", w, 32'd8);
        for (int p = 0; p < 8; p++) begin
            n = 0;
            while (jclk === 1'b1 && n < 100) begin @(negedge clk); n++; end
            w = 0;
            while (jclk === 1'b0 && w < 100) begin @(negedge clk); w++; end
            chk($sformatf("clk_low%0d", p), w, 32'd4);
        end
        n = 0; extra = 0;
        while (jlat !== 1'b1 && n < 400) begin
            if (jclk === 1'b0) extra++;
            @(negedge clk); n++;
        end
        chk("extra_clk_low", extra, 32'd0);
        chk("scan_period", cyc - t0, 32'd112);

        // A pressed on pad 1, pad 2 released.
        pad1_lv = 8'hFE; pad2_lv = 8'hFF;
        wait_scan();
        snap1 = ~pad1_lv; snap2 = ~pad2_lv;
        strobe_pulse();
        for (int k = 0; k < 8; k++) begin
            bus_read(16'h4016, v);
            chk($sformatf("p1_rd%0d", k), v, {7'd0, exp_rd(snap1, k)});
        end
        for (int k = 0; k < 8; k++) begin
            bus_read(16'h4017, v);
            chk($sformatf("p2_rd%0d", k), v, {7'd0, exp_rd(snap2, k)});
        end
        for (int k = 8; k < 10; k++) begin
            bus_read(16'h4016, v);
            chk($sformatf("p1_rd%0d", k), v, 32'h01);
        end

        // Strobe held: Right pressed, then A pressed mid-strobe.
        pad1_lv = 8'h7F;
        wait_scan();
        bus_write(16'h4016, 8'h01);
        for (int k = 0; k < 3; k++) begin
            bus_read(16'h4016, v);
            chk($sformatf("strobe_rd%0d", k), v, 32'h00);
        end
        pad1_lv = 8'h7E;
        wait_scan();
        bus_read(16'h4016, v);
        chk("strobe_a_live", v, 32'h01);
        bus_read(16'h4016, v);
        chk("strobe_noshift", v, 32'h01);
        bus_write(16'h4016, 8'h00);
        snap1 = ~pad1_lv;
        for (int k = 0; k < 9; k++) begin
            bus_read(16'h4016, v);
            chk($sformatf("ar_rd%0d", k), v, {7'd0, exp_rd(snap1, k)});
        end

        // Reset in the middle of LATCH.
        bus_if.a_in = 16'h4016;
        n = 0;
        while (jlat !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        #1 rst = 1'b1;
        #1;
        chk("midrst_jlat", jlat, 32'd0);
        chk("midrst_jclk", jclk, 32'd1);
        chk("midrst_dout", bus_if.d_out, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        bus_if.a_in = 16'h0000;
        strobe_pulse();
        bus_read(16'h4016, v);
        chk("midrst_btn1", v, 32'h00);

        // Randomized pads and interleaved accesses against the read model.
        for (int it = 0; it < 4; it++) begin
            pad1_lv = 8'($urandom); pad2_lv = 8'($urandom);
            wait_scan();
            snap1 = ~pad1_lv; snap2 = ~pad2_lv;
            strobe_pulse();
            r1 = 0; r2 = 0;
            for (int s = 0; s < 24; s++) begin
                sel = int'($urandom_range(0, 4));
                if (sel <= 1) begin
                    bus_read(16'h4016, v);
                    chk($sformatf("rnd%0d_p1_%0d", it, r1), v, {7'd0, exp_rd(snap1, r1)});
                    r1++;
                end else if (sel == 2) begin
                    bus_read(16'h4017, v);
                    chk($sformatf("rnd%0d_p2_%0d", it, r2), v, {7'd0, exp_rd(snap2, r2)});
                    r2++;
                end else if (sel == 3) begin
                    bus_read(($urandom_range(0, 1) == 0) ? 16'h4015 : 16'h2002, v);
                    chk($sformatf("rnd%0d_other", it), v, 32'h00);
                end else begin
                    bus_write(16'h4017, 8'h01);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
